// File: rtl/sfp_sched_pkg.sv
// sfp_sched_pkg: shared opcode enum, width helper and op-counter width for sfp_add_sched.
package sfp_sched_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  localparam int OPC_W = 16;
  // Index width for n requesters, never below one bit.
  function automatic int idw_f(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, lowest requester at or above ptr, else lowest overall.
// Ports: req  - request vector
//        ptr  - search start index (state held by the parent)
//        grant - one-hot grant, zero when no request
module rr_arbiter import sfp_sched_pkg::*; #(
  parameter int N = 4,
  localparam int PW = idw_f(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [N-1:0] w_hi;
  logic [N-1:0] w_pick;
  assign w_hi   = req & ({N{1'b1}} << ptr);
  assign w_pick = (|w_hi) ? w_hi : req;
  // Isolate the lowest set bit.
  assign grant  = w_pick & (~w_pick + N'(1));
endmodule

// File: rtl/sfp_add_sched.sv
// sfp_add_sched: round-robin shared signed fixed-point adder/subtractor, 1-cycle latency, full-precision result.
// Ports: clk_i, rst_ni (async active-low)
//        req_valid_i/req_ready_o   per-requester handshake, ready is one-hot or zero
//        req_a_i/req_b_i           packed signed operands, requester i at [i*W +: W]
//        req_sub_i                 per-requester opcode (1 = A-B)
//        rsp_valid_o/rsp_ready_i   result handshake
//        rsp_data_o/rsp_id_o       RW-bit result and owning requester index
//        op_count_o                accepted-operation count, wraps at 16 bits
// Macro: SFP_ADD_SCHED_SUB_EN enables subtraction; without it every operation is A+B.
module sfp_add_sched import sfp_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IW = 8,
  parameter int QW = 8,
  localparam int W = IW + QW,
  localparam int RW = W + 1,
  localparam int IDW = idw_f(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*W-1:0] req_a_i,
  input  logic [NREQ*W-1:0] req_b_i,
  input  logic [NREQ-1:0]   req_sub_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [RW-1:0]     rsp_data_o,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [OPC_W-1:0]  op_count_o
);
  logic              r_rsp_valid;
  logic [RW-1:0]     r_rsp_data;
  logic [IDW-1:0]    r_rsp_id;
  logic [IDW-1:0]    r_ptr;
  logic [OPC_W-1:0]  r_cnt;
  logic [NREQ-1:0]   w_grant;
  logic              w_slot_free;
  logic              w_xfer;
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;
  logic              w_sub;
  op_e               w_op;
  logic [RW-1:0]     w_ax;
  logic [RW-1:0]     w_bx;
  logic [RW-1:0]     w_res;
  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid_i),
    .ptr   (r_ptr),
    .grant (w_grant)
  );
  assign w_slot_free = !r_rsp_valid || rsp_ready_i;
  // Gating with rst_ni keeps ready low while reset is held, independent of inputs.
  assign req_ready_o = w_grant & {NREQ{w_slot_free && rst_ni}};
  assign w_xfer      = |(req_valid_i & req_ready_o);
  always_comb begin
    w_idx = '0;
    w_a   = '0;
    w_b   = '0;
    w_sub = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) begin
        w_idx = IDW'(i);
        w_a   = req_a_i[i*W +: W];
        w_b   = req_b_i[i*W +: W];
        w_sub = req_sub_i[i];
      end
  end
`ifdef SFP_ADD_SCHED_SUB_EN
  assign w_op = op_e'(w_sub);
`else
  logic w_unused_sub;
  assign w_unused_sub = w_sub;
  assign w_op = OP_ADD;
`endif
  // One extra sign bit makes the sum/difference exact.
  assign w_ax      = {w_a[W-1], w_a};
  assign w_bx      = {w_b[W-1], w_b};
  assign w_res     = (w_op == OP_SUB) ? w_ax - w_bx : w_ax + w_bx;
  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_res;
      r_rsp_id    <= w_idx;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= r_cnt + 1'b1;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_id_o    = r_rsp_id;
  assign op_count_o  = r_cnt;
endmodule

// File: tb/tb_sfp_add_sched.sv
// tb_sfp_add_sched: directed vector table, fairness/backpressure/reset sequences and random traffic vs a behavioural model.
module tb_sfp_add_sched;
  localparam int N = 4;
  localparam int W = 16;
  localparam int RW = 17;
  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*W-1:0]  req_a_i = '0;
  logic [N*W-1:0]  req_b_i = '0;
  logic [N-1:0]    req_sub_i = '0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b1;
  logic [RW-1:0]   rsp_data_o;
  logic [1:0]      rsp_id_o;
  logic [15:0]     op_count_o;
  int total = 0;
  int bad = 0;
  int m_ptr = 0;
  int m_valid = 0;
  logic [RW-1:0] m_data = '0;
  int m_id = 0;
  int m_cnt = 0;
  int m_last = -1;
  sfp_add_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_sub_i(req_sub_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .op_count_o(op_count_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  // Arithmetic model: exact signed sum/difference of the two 16-bit operands, kept to 17 bits.
  function automatic logic [RW-1:0] model_op(input int id);
    int a, b, r;
    logic sub;
    a = int'($signed(req_a_i[id*W +: W]));
    b = int'($signed(req_b_i[id*W +: W]));
`ifdef SFP_ADD_SCHED_SUB_EN
    sub = req_sub_i[id];
`else
    sub = 1'b0;
`endif
    r = sub ? a - b : a + b;
    return r[RW-1:0];
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; m_cnt = 0; m_last = -1;
  endtask
  // One clock: check ready before the edge, advance the model on the edge, check registers after.
  task automatic cycle();
    int gi;
    logic [N-1:0] exp_rdy;
    #1;
    gi = -1;
    for (int k = 0; k < N; k++)
      if (gi < 0 && req_valid_i[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
    exp_rdy = '0;
    if (rst_ni && gi >= 0 && (m_valid == 0 || rsp_ready_i)) exp_rdy[gi] = 1'b1;
    chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    @(posedge clk_i);
    m_last = -1;
    if (!rst_ni) model_reset();
    else if (exp_rdy != 0) begin
      m_valid = 1; m_data = model_op(gi); m_id = gi;
      m_ptr = (gi + 1) % N; m_cnt = (m_cnt + 1) & 16'hFFFF; m_last = gi;
    end else if (rsp_ready_i) m_valid = 0;
    #1;
    chk("rsp_valid", 32'(rsp_valid_o), 32'(m_valid));
    chk("op_count", 32'(op_count_o), 32'(m_cnt));
    if (m_valid != 0) begin
      chk("rsp_data", 32'(rsp_data_o), 32'(m_data));
      chk("rsp_id", 32'(rsp_id_o), 32'(m_id));
    end
  endtask
  typedef struct {
    int id;
    logic [15:0] a;
    logic [15:0] b;
    logic sub;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[6];
  initial begin
    logic [RW-1:0] held;
    int ids[5];
    tbl[0] = '{2, 16'h0180, 16'h0240, 1'b0, 17'h003C0};
    tbl[1] = '{1, 16'hFF00, 16'h0080, 1'b0, 17'h1FF80};
    tbl[2] = '{3, 16'h7FFF, 16'h7FFF, 1'b0, 17'h0FFFE};
`ifdef SFP_ADD_SCHED_SUB_EN
    tbl[3] = '{0, 16'h0100, 16'h0200, 1'b1, 17'h1FF00};
    tbl[5] = '{0, 16'h8000, 16'h7FFF, 1'b1, 17'h10001};
`else
    tbl[3] = '{0, 16'h0100, 16'h0200, 1'b1, 17'h00300};
    tbl[5] = '{0, 16'h8000, 16'h7FFF, 1'b1, 17'h1FFFF};
`endif
    tbl[4] = '{1, 16'h8000, 16'h8000, 1'b0, 17'h10000};
    // Reset with every requester asking.
    req_valid_i = '1;
    repeat (2) cycle();
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_valid", 32'(rsp_valid_o), 0);
    chk("rst_count", 32'(op_count_o), 0);
    chk("rst_data", 32'(rsp_data_o), 0);
    chk("rst_id", 32'(rsp_id_o), 0);
    req_valid_i = '0;
    rst_ni = 1'b1;
    cycle();
    // Directed vector table, one requester at a time.
    for (int i = 0; i < 6; i++) begin
      req_valid_i = '0;
      req_valid_i[tbl[i].id] = 1'b1;
      req_a_i[tbl[i].id*W +: W] = tbl[i].a;
      req_b_i[tbl[i].id*W +: W] = tbl[i].b;
      req_sub_i[tbl[i].id] = tbl[i].sub;
      rsp_ready_i = 1'b1;
      cycle();
      chk($sformatf("vec%0d_data", i), 32'(rsp_data_o), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_id", i), 32'(rsp_id_o), 32'(tbl[i].id));
      if (i == 0) chk("vec0_count", 32'(op_count_o), 1);
      req_valid_i = '0;
      cycle();
    end
    // Load a result under backpressure, then reset asynchronously mid-cycle.
    req_valid_i = 4'b0010;
    rsp_ready_i = 1'b0;
    cycle();
    req_valid_i = '1;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_valid", 32'(rsp_valid_o), 0);
    chk("async_count", 32'(op_count_o), 0);
    chk("async_ready", 32'(req_ready_o), 0);
    cycle();
    rst_ni = 1'b1;
    // Fairness: all requesters held, downstream always ready.
    for (int i = 0; i < N; i++) begin
      req_a_i[i*W +: W] = 16'(i * 16'h0100);
      req_b_i[i*W +: W] = 16'h0001;
    end
    req_sub_i = '0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      ids[i] = int'(rsp_id_o);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("fair%0d", i), 32'(ids[i]), 32'(i % 4));
    chk("fair_count", 32'(op_count_o), 5);
    // Backpressure for 5 cycles, then release.
    rsp_ready_i = 1'b0;
    held = rsp_data_o;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_ready", 32'(req_ready_o), 0);
      chk("bp_hold", 32'(rsp_data_o), 32'(held));
      chk("bp_count", 32'(op_count_o), 5);
    end
    rsp_ready_i = 1'b1;
    cycle();
    chk("bp_next_id", 32'(rsp_id_o), 1);
    // Random traffic; a requester keeps its operands until it transfers.
    req_valid_i = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_i[i] || m_last == i) begin
          req_valid_i[i] = 1'($urandom_range(0, 1));
          req_a_i[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
          req_b_i[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
          req_sub_i[i] = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sfp_add_sched.md
SFP_ADD_SCHED -- requirements
Module: sfp_add_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the adder (2..16).
REQ-002 Parameter IW, default 8: integer bits of each operand, sign included.
REQ-003 Parameter QW, default 8: fractional bits of each operand.
REQ-004 Derived widths: W = IW+QW for operands; RW = W+1 for results (full precision, iw+1/qw); IDW = max(1, clog2(NREQ)).
REQ-005 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 req_valid_i  in  NREQ  per-requester request valid.
REQ-008 req_ready_o  out  NREQ  per-requester accept; one-hot or zero.
REQ-009 req_a_i  in  NREQ*W  packed signed operand A; requester i occupies bits [i*W +: W].
REQ-010 req_b_i  in  NREQ*W  packed signed operand B; same packing as A.
REQ-011 req_sub_i  in  NREQ  per-requester opcode: 1 = A-B, 0 = A+B.
REQ-012 rsp_valid_o  out  1  result valid.
REQ-013 rsp_ready_i  in  1  downstream accept.
REQ-014 rsp_data_o  out  RW  signed full-precision result.
REQ-015 rsp_id_o  out  IDW  index of the requester that owns the result.
REQ-016 op_count_o  out  16  count of accepted operations; wraps from 0xFFFF to 0.

Function
REQ-017 A transfer on requester i occurs when req_valid_i[i] && req_ready_o[i]; a requester holds valid, operands and opcode stable until its transfer.
REQ-018 slot_free = !rsp_valid_o || rsp_ready_i.
- req_ready_o[i] = grant[i] && slot_free.
- grant is combinational from req_valid_i and the round-robin pointer.
REQ-019 Round-robin grant: the lowest index >= ptr with valid set wins; if none, search wraps to index 0.
- On a transfer, ptr <= (granted index + 1) mod NREQ.
- No transfer: ptr holds.
REQ-020 Operands are sign-extended to RW bits before the operation.
- rsp_data_o is the exact RW-bit sum or difference; no overflow, rounding or clipping is possible.
REQ-021 Latency is exactly 1 cycle.
- The cycle after a transfer, rsp_valid_o=1 and rsp_data_o/rsp_id_o carry that result.
- The output register holds its contents until rsp_ready_i.
REQ-022 Simultaneous rsp_ready_i and a new transfer in the same cycle: the output register reloads with the new result and rsp_valid_o stays 1, giving full throughput of 1 op/cycle.
REQ-023 rsp_ready_i with no transfer clears rsp_valid_o the next cycle.
REQ-024 Backpressure (rsp_valid_o=1, rsp_ready_i=0): all req_ready_o=0, and ptr and op_count_o hold.
REQ-025 op_count_o increments by 1 on each transfer.

Reset
REQ-026 While rst_ni=0, and immediately on its assertion:
- rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0;
- ptr=0, op_count_o=0;
- req_ready_o=0 regardless of inputs.
REQ-027 Reset asserted mid-operation discards any pending result; no transfer is counted in a reset cycle.

Configuration
REQ-028 Macro SFP_ADD_SCHED_SUB_EN.
- Defined: req_sub_i selects A-B per REQ-011.
- Undefined: req_sub_i is present but ignored, and every operation is A+B.

Structure
REQ-029 Package sfp_sched_pkg holds:
- the opcode enum (OP_ADD, OP_SUB);
- the IDW width function;
- the op-counter width constant (16).
REQ-030 Round-robin arbitration is a separate sub-module rr_arbiter with ports req, ptr and grant, parameterised by N.
- It is purely combinational.
- Pointer state stays in sfp_add_sched.

Verification
REQ-031 Reset and defaults (IW=8, QW=8, NREQ=4): hold rst_ni=0 with all req_valid_i=1 -> req_ready_o=0, rsp_valid_o=0, op_count_o=0.
REQ-032 Single add:
- Stimulus: requester 2, A=0x0180 (1.5), B=0x0240 (2.25), rsp_ready_i=1.
- Response: next cycle rsp_data_o=0x003C0 (3.75), rsp_id_o=2, op_count_o=1.
REQ-033 Sign and extremes:
- A=0xFF00 (-1.0), B=0x0080 (0.5) -> 0x1FF80 (-0.5).
- A=B=0x7FFF -> 0x0FFFE, no wrap.
REQ-034 Fairness: all four requesters held valid, rsp_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_id_o following one cycle later, 1 op/cycle.
REQ-035 Backpressure:
- rsp_ready_i=0 for 5 cycles with requests pending -> result held stable, req_ready_o=0, op_count_o frozen.
- On release, the next grant goes to the requester following the last granted one.
REQ-036 Subtract with SFP_ADD_SCHED_SUB_EN:
- Defined: A=0x0100 (1.0), B=0x0200 (2.0), req_sub_i=1 -> 0x1FF00 (-1.0).
- Undefined, same stimulus: 0x00300 (3.0).
